// File: rtl/scoreboard_pkg.sv
// Shared constants and types for the imhotep register-hazard scoreboard.
package scoreboard_pkg;
  localparam int unsigned RFADDR       = 5;
  localparam int unsigned SB_CNT_W     = 2;
  localparam int unsigned NUM_WB_PORTS = 2;

  typedef logic [SB_CNT_W-1:0] sb_cnt_t;
endpackage

// File: rtl/scoreboard_if.sv
// Decoder/writeback-facing signal bundle of the scoreboard.
interface scoreboard_if #(
  parameter int unsigned RFADDR   = scoreboard_pkg::RFADDR,
  parameter int unsigned NUM_WB   = scoreboard_pkg::NUM_WB_PORTS,
  parameter int unsigned NUM_REGS = 2**RFADDR
);
  logic [RFADDR-1:0]        query_1_i;
  logic [RFADDR-1:0]        query_2_i;
  logic                     query_answer_1_o;
  logic                     query_answer_2_o;
  logic [RFADDR-1:0]        query_rd_i;
  logic                     rd_full_o;
  logic [RFADDR-1:0]        commit_i;
  logic [NUM_WB-1:0]        wb_valid_i;
  logic [NUM_WB*RFADDR-1:0] wb_addr_i;
  logic                     flush_i;
  logic [NUM_REGS-1:0]      busy_vec_o;
  logic                     err_o;

  modport master (
    output query_1_i, query_2_i, query_rd_i, commit_i, wb_valid_i, wb_addr_i, flush_i,
    input  query_answer_1_o, query_answer_2_o, rd_full_o, busy_vec_o, err_o
  );

  modport slave (
    input  query_1_i, query_2_i, query_rd_i, commit_i, wb_valid_i, wb_addr_i, flush_i,
    output query_answer_1_o, query_answer_2_o, rd_full_o, busy_vec_o, err_o
  );
endinterface

// File: rtl/scoreboard_sb_counter.sv
// Per-register saturating pending-write counter with net inc/dec update.
module sb_counter #(
  parameter int unsigned CNT_W = scoreboard_pkg::SB_CNT_W,
  parameter int unsigned DEC_W = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  input  logic [DEC_W-1:0] dec_i,
  input  logic             flush_i,
  output logic [CNT_W-1:0] count_o,
  output logic             busy_o,
  output logic             full_o,
  output logic             ovf_o,
  output logic             unf_o
);
  localparam int unsigned SW = ((CNT_W + 1) > DEC_W) ? (CNT_W + 1) : DEC_W;
  localparam logic [CNT_W-1:0] MAX = '1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SW-1:0]    sum, dec_ext;

  // Flags are suppressed under flush so a redirect never raises err_o.
  always_comb begin
    sum     = SW'(cnt_q) + SW'(inc_i);
    dec_ext = SW'(dec_i);
    ovf_o   = !flush_i && (cnt_q == MAX) && inc_i && (dec_i == '0);
    unf_o   = !flush_i && (sum < dec_ext);
    if (flush_i)    cnt_d = '0;
    else if (ovf_o) cnt_d = MAX;
    else if (unf_o) cnt_d = '0;
    else            cnt_d = CNT_W'(sum - dec_ext);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign count_o = cnt_q;
  assign busy_o  = (cnt_q != '0);
  assign full_o  = (cnt_q == MAX);
endmodule

// File: rtl/scoreboard.sv
// Register-hazard scoreboard: per-register pending-write tracking and RAW queries.
module scoreboard
  import scoreboard_pkg::*;
#(
  parameter int unsigned RFADDR    = scoreboard_pkg::RFADDR,
  parameter int unsigned NUM_REGS  = 2**RFADDR,
  parameter int unsigned CNT_W     = SB_CNT_W,
  parameter int unsigned NUM_WB    = NUM_WB_PORTS,
  parameter int unsigned WB_BYPASS = 0
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  scoreboard_if.slave  sb
);
  localparam int unsigned DEC_W = $clog2(NUM_WB + 1);

  logic [NUM_REGS-1:0] busy, full, rel_any;
  logic [NUM_REGS-1:1] ovf_vec, unf_vec;
  logic [DEC_W-1:0]    dec_cnt [NUM_REGS];
  logic [CNT_W-1:0]    cnt     [NUM_REGS];
  logic                err_q;

  always_comb begin
    rel_any = '0;
    for (int unsigned r = 0; r < NUM_REGS; r++) dec_cnt[r] = '0;
    for (int unsigned r = 1; r < NUM_REGS; r++) begin
      for (int unsigned k = 0; k < NUM_WB; k++) begin
        if (sb.wb_valid_i[k] && (sb.wb_addr_i[k*RFADDR +: RFADDR] == RFADDR'(r))) begin
          dec_cnt[r] = dec_cnt[r] + DEC_W'(1);
          rel_any[r] = 1'b1;
        end
      end
    end
  end

  assign busy[0] = 1'b0;
  assign full[0] = 1'b0;
  assign cnt[0]  = '0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_cnt
    sb_counter #(.CNT_W(CNT_W), .DEC_W(DEC_W)) u_cnt (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .inc_i   (sb.commit_i == RFADDR'(r)),
      .dec_i   (dec_cnt[r]),
      .flush_i (sb.flush_i),
      .count_o (cnt[r]),
      .busy_o  (busy[r]),
      .full_o  (full[r]),
      .ovf_o   (ovf_vec[r]),
      .unf_o   (unf_vec[r])
    );
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) err_q <= 1'b0;
    else         err_q <= |{ovf_vec, unf_vec};
  end

  // Bypass hides a hazard whose last pending write retires this cycle, unless it is re-reserved.
  always_comb begin
    sb.query_answer_1_o = (sb.query_1_i != '0) && busy[sb.query_1_i];
    sb.query_answer_2_o = (sb.query_2_i != '0) && busy[sb.query_2_i];
    if (WB_BYPASS != 0) begin
      if ((cnt[sb.query_1_i] == CNT_W'(1)) && rel_any[sb.query_1_i] && (sb.commit_i != sb.query_1_i))
        sb.query_answer_1_o = 1'b0;
      if ((cnt[sb.query_2_i] == CNT_W'(1)) && rel_any[sb.query_2_i] && (sb.commit_i != sb.query_2_i))
        sb.query_answer_2_o = 1'b0;
    end
  end

  assign sb.rd_full_o  = (sb.query_rd_i != '0) && full[sb.query_rd_i];
  assign sb.busy_vec_o = busy;
  assign sb.err_o      = err_q;
endmodule

// File: doc/scoreboard.md
Name: scoreboard

Overview:
- Register-hazard scoreboard for the imhotep pipeline; sits beside decoder and register file.
- Tracks outstanding writes per architectural register.
  - Decode issues a write reservation.
  - Writeback ports release it.
- Answers decoder's two source-operand queries and one destination-capacity query combinationally, so decode can stall on RAW hazards.

Parameters:
NUM_REGS, 2**RFADDR, number of architectural registers tracked (x0 included, never busy)
CNT_W, 2, width of per-register pending counter; max outstanding writes per register = 2**CNT_W-1
NUM_WB, 2, number of writeback release ports (ALU, LSU)
WB_BYPASS, 0, 1 = same-cycle release clears query answer combinationally; 0 = answers reflect registered state only

Ports:
clk_i  input  1  clock
rst_ni  input  1  asynchronous active-low reset
query_1_i  input  RFADDR  rs1 address from decoder
query_2_i  input  RFADDR  rs2 address from decoder
query_answer_1_o  output  1  rs1 has pending write (stall)
query_answer_2_o  output  1  rs2 has pending write (stall)
query_rd_i  input  RFADDR  rd of instruction in decode
rd_full_o  output  1  rd counter saturated; decode must stall
commit_i  input  RFADDR  reservation address; 0 = no reservation this cycle
wb_valid_i  input  NUM_WB  per-port release valid
wb_addr_i  input  NUM_WB*RFADDR  per-port release address, port k at bits [k*RFADDR +: RFADDR]
flush_i  input  1  clear all reservations (redirect/exception)
busy_vec_o  output  NUM_REGS  bit r = counter[r] != 0 (registered)
err_o  output  1  one-cycle pulse on illegal update (overflow/underflow)

Behaviour:
- Reset (rst_ni low, async): all counters 0, err_o 0, busy_vec_o all 0. Outputs are valid from the first edge after deassertion.
- State: counter[r], CNT_W bits, for r = 1..NUM_REGS-1. counter[0] is constant 0.
- Per-cycle update, evaluated per register r:
  - inc = (commit_i == r) && r != 0
  - dec = number of ports k with wb_valid_i[k] && wb_addr_i[k] == r && r != 0 (0..NUM_WB)
  - next = counter + inc - dec
- Overflow:
  - Condition: counter == max && inc && dec == 0.
  - Counter holds at max; err_o pulses next cycle.
- Underflow:
  - Condition: counter + inc < dec.
  - Counter goes to 0; err_o pulses next cycle.
- Commit and release of the same register in the same cycle:
  - Net change only; e.g. count 1, inc 1, dec 1 -> stays 1.
- flush_i has priority over commit and writeback in the same cycle:
  - All counters 0 next cycle.
  - No err_o for that cycle's updates.
- query_answer_n_o = (query_n_i != 0) && counter[query_n_i] != 0.
  - With WB_BYPASS=1, the answer is additionally masked when counter==1, some wb port releases that register this cycle, and commit_i != that register.
- rd_full_o = (query_rd_i != 0) && counter[query_rd_i] == max. Never subject to bypass.
- Latency:
  - Commit visible to queries the next cycle (1-cycle).
  - Release visible the next cycle (0 with bypass).
- Address 0 on any port is ignored entirely.
- err_o is a registered single-cycle pulse. Simultaneous errors on several registers still give one pulse.
- Reset asserted mid-operation clears all state immediately, regardless of clock.

Decomposition:
- Add to imhotep_pkg:
  - SB_CNT_W localparam
  - sb_cnt_t typedef (logic [SB_CNT_W-1:0])
  - NUM_WB_PORTS constant
- One natural sub-module, sb_counter: a single-register saturating up/down counter.
  - Inputs: inc, dec count, flush.
  - Outputs: count, busy, full, ovf/unf flags.
  - Instantiated NUM_REGS-1 times via generate.
- Top level does the address decode and the query muxing.

Test Plan:
- Reset: hold rst_ni=0 mid-traffic with commit_i=5 -> busy_vec_o=0, err_o=0, query_answer_1_o=0 for query_1_i=5.
- RAW hazard: commit_i=3 in cycle 0 -> cycle 1 query_1_i=3 gives answer 1; wb_valid_i[0]=1, wb_addr_i=3 in cycle 2 -> cycle 3 answer 0 (WB_BYPASS=0); with WB_BYPASS=1 answer is 0 already in cycle 2.
- Multiple outstanding: commit x7 three times -> rd_full_o=1 for query_rd_i=7; fourth commit -> err_o pulse, count stays 3; two releases on ports 0 and 1 in one cycle -> count 1.
- Simultaneous: count[4]=1, commit_i=4 plus wb port0 addr 4 in the same cycle -> count stays 1, err_o=0.
- Underflow/x0: release x9 with count 0 -> err_o pulse, count 0; commit_i=0 and query_1_i=0 -> answer 0, no state change.
- Flush priority: x2=2 and x6=1 pending, flush_i=1 with commit_i=2 the same cycle -> next cycle busy_vec_o=0, err_o=0.
